fft_packet_scheduler: RTL and testbench

- Per-packet sequencer placed in front of the multi-instance FFT pipeline wrapper.
- Accepts one command per FFT packet carrying the FFT config, CP removal length and CP insertion length.
- Issues the three side-channel tokens, then admits exactly one data packet into the pipeline.
- Tracks packets in flight and throttles new commands when the pipeline holds MAX_OUTSTANDING packets; optionally checks that input packet length matches the command.

---
 rtl/fft_packet_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_fft_packet_scheduler.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_packet_scheduler.sv
// Per-packet sequencer ahead of the FFT pipeline: one command -> three side-channel tokens -> one data packet.
// Optional input-length checking is compiled in with `define FFT_SCHED_LEN_CHECK_EN.
module fft_packet_scheduler #(
  parameter int NIPC              = 1,
  parameter int MAX_FFT_SIZE_LOG2 = 12,
  parameter int FFT_CONFIG_W      = 16,
  parameter int MAX_OUTSTANDING   = 4,
  localparam int CP_LEN_W         = MAX_FFT_SIZE_LOG2,
  localparam int SIZE_W           = $clog2(MAX_FFT_SIZE_LOG2 + 1),
  localparam int DW               = NIPC * 32,
  localparam int CMD_W            = FFT_CONFIG_W + 2 * CP_LEN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SIZE_W-1:0]       fft_size_log2,
  input  logic [CMD_W-1:0]        cmd_tdata,
  input  logic                    cmd_tvalid,
  output logic                    cmd_tready,
  output logic [FFT_CONFIG_W-1:0] fft_config_tdata,
  output logic                    fft_config_tvalid,
  input  logic                    fft_config_tready,
  output logic [CP_LEN_W-1:0]     cp_rem_tdata,
  output logic                    cp_rem_tvalid,
  input  logic                    cp_rem_tready,
  output logic [CP_LEN_W-1:0]     cp_ins_tdata,
  output logic                    cp_ins_tvalid,
  input  logic                    cp_ins_tready,
  input  logic [DW-1:0]           i_tdata,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [DW-1:0]           p_tdata,
  output logic                    p_tlast,
  output logic                    p_tvalid,
  input  logic                    p_tready,
  input  logic                    done_tlast,
  input  logic                    done_tvalid,
  input  logic                    done_tready,
  output logic [3:0]              outstanding,
  output logic                    err_len,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  // All streams: a beat transfers on a rising edge where tvalid && tready; a source holds
  // tvalid and tdata stable until that edge and never waits on tready before asserting tvalid.

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, PASS = 2'd2} state_t;

  state_t     state, state_next;
  logic       cmd_acc;
  logic       pkt_end;
  logic       pkt_done;
  logic [3:0] outstanding_next;

  assign cmd_acc  = cmd_tvalid & cmd_tready;
  assign pkt_end  = p_tvalid & p_tready & p_tlast;
  assign pkt_done = done_tvalid & done_tready & done_tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    p_tdata    = i_tdata;
    p_tlast    = i_tlast;
    p_tvalid   = 1'b0;
    i_tready   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_acc) state_next = ISSUE;
      end
      ISSUE: begin
        // Leave once every token is either already gone or handshaking this cycle.
        if (!((fft_config_tvalid & ~fft_config_tready) |
              (cp_rem_tvalid & ~cp_rem_tready) |
              (cp_ins_tvalid & ~cp_ins_tready)))
          state_next = PASS;
      end
      PASS: begin
        p_tvalid = i_tvalid;
        i_tready = p_tready;
        if (i_tvalid & p_tready & i_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fft_config_tvalid <= 1'b0;
      cp_rem_tvalid     <= 1'b0;
      cp_ins_tvalid     <= 1'b0;
      fft_config_tdata  <= '0;
      cp_rem_tdata      <= '0;
      cp_ins_tdata      <= '0;
    end else if (cmd_acc) begin
      fft_config_tvalid <= 1'b1;
      cp_rem_tvalid     <= 1'b1;
      cp_ins_tvalid     <= 1'b1;
      fft_config_tdata  <= cmd_tdata[FFT_CONFIG_W-1:0];
      cp_rem_tdata      <= cmd_tdata[FFT_CONFIG_W +: CP_LEN_W];
      cp_ins_tdata      <= cmd_tdata[FFT_CONFIG_W+CP_LEN_W +: CP_LEN_W];
    end else begin
      fft_config_tvalid <= fft_config_tvalid & ~fft_config_tready;
      cp_rem_tvalid     <= cp_rem_tvalid & ~cp_rem_tready;
      cp_ins_tvalid     <= cp_ins_tvalid & ~cp_ins_tready;
    end
  end

  always_comb begin
    outstanding_next = outstanding;
    if (pkt_end && !pkt_done)
      outstanding_next = outstanding + 4'd1;
    else if (pkt_done && !pkt_end && outstanding != 4'd0)
      outstanding_next = outstanding - 4'd1;
  end

  // cmd_tready looks at the post-update count, so a decrement reopens it exactly one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= 4'd0;
      cmd_tready  <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      cmd_tready  <= (state_next == IDLE) && (outstanding_next < 4'(MAX_OUTSTANDING));
    end
  end

  assign busy = (state != IDLE) || (outstanding != 4'd0);

`ifdef FFT_SCHED_LEN_CHECK_EN
  localparam int NIPC_LOG2 = $clog2(NIPC);

  logic [CP_LEN_W:0] exp_calc;
  logic [CP_LEN_W:0] exp_beats;
  logic [CP_LEN_W:0] beat_cnt;
  logic [CP_LEN_W:0] beat_num;
  logic              len_flag;
  logic              err_r;

  assign exp_calc = (((CP_LEN_W+1)'(1) << fft_size_log2) +
                     {1'b0, cmd_tdata[FFT_CONFIG_W +: CP_LEN_W]}) >> NIPC_LOG2;
  assign beat_num = beat_cnt + (CP_LEN_W+1)'(1);

  // len_flag remembers an early "reached expected without tlast" report so tlast stays silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_beats <= '0;
      beat_cnt  <= '0;
      len_flag  <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      err_r <= 1'b0;
      if (cmd_acc) begin
        exp_beats <= exp_calc;
        beat_cnt  <= '0;
        len_flag  <= 1'b0;
      end else if (p_tvalid && p_tready) begin
        if (p_tlast) begin
          beat_cnt <= '0;
          err_r    <= !len_flag && (beat_num != exp_beats);
        end else if (!len_flag) begin
          beat_cnt <= beat_num;
          if (beat_num == exp_beats) begin
            err_r    <= 1'b1;
            len_flag <= 1'b1;
          end
        end
      end
    end
  end

  assign err_len = err_r;
`else
  logic unused_size;
  assign unused_size = ^fft_size_log2;
  assign err_len     = 1'b0;
`endif

endmodule

// File: tb/tb_fft_packet_scheduler.sv
// Self-checking bench for fft_packet_scheduler: directed scenario tasks plus a data scoreboard on p_*.
// Build with FFT_SCHED_LEN_CHECK_EN defined to exercise the length checker (NIPC=4 then).
`timescale 1ns/1ps
module tb_fft_packet_scheduler;

`ifdef FFT_SCHED_LEN_CHECK_EN
  localparam int NIPC = 4;
`else
  localparam int NIPC = 1;
`endif
  localparam int NIPC_LOG2 = $clog2(NIPC);
  localparam int MAXL2     = 12;
  localparam int CFG_W     = 16;
  localparam int MAX_OUT   = 4;
  localparam int CP_W      = MAXL2;
  localparam int SIZE_W    = $clog2(MAXL2 + 1);
  localparam int DW        = NIPC * 32;
  localparam int CMD_W     = CFG_W + 2 * CP_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SIZE_W-1:0] fft_size_log2;
  logic [CMD_W-1:0]  cmd_tdata;
  logic              cmd_tvalid, cmd_tready;
  logic [CFG_W-1:0]  fft_config_tdata;
  logic              fft_config_tvalid, fft_config_tready;
  logic [CP_W-1:0]   cp_rem_tdata, cp_ins_tdata;
  logic              cp_rem_tvalid, cp_rem_tready, cp_ins_tvalid, cp_ins_tready;
  logic [DW-1:0]     i_tdata, p_tdata;
  logic              i_tlast, i_tvalid, i_tready;
  logic              p_tlast, p_tvalid, p_tready;
  logic              done_tlast, done_tvalid, done_tready;
  logic [3:0]        outstanding;
  logic              err_len, busy;
  logic [1:0]        dbg_state;

  int tests_run = 0;
  int fails     = 0;
  int err_cnt   = 0;
  logic [DW:0] exp_q[$];

  fft_packet_scheduler #(
    .NIPC(NIPC), .MAX_FFT_SIZE_LOG2(MAXL2), .FFT_CONFIG_W(CFG_W), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fft_size_log2(fft_size_log2),
    .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
    .fft_config_tdata(fft_config_tdata), .fft_config_tvalid(fft_config_tvalid),
    .fft_config_tready(fft_config_tready),
    .cp_rem_tdata(cp_rem_tdata), .cp_rem_tvalid(cp_rem_tvalid), .cp_rem_tready(cp_rem_tready),
    .cp_ins_tdata(cp_ins_tdata), .cp_ins_tvalid(cp_ins_tvalid), .cp_ins_tready(cp_ins_tready),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .p_tdata(p_tdata), .p_tlast(p_tlast), .p_tvalid(p_tvalid), .p_tready(p_tready),
    .done_tlast(done_tlast), .done_tvalid(done_tvalid), .done_tready(done_tready),
    .outstanding(outstanding), .err_len(err_len), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_tvalid = 1'b0;
    i_tvalid = 1'b0;
    i_tlast = 1'b0;
    done_tvalid = 1'b0;
    done_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic int exp_len(int sz, int rem);
    return ((1 << sz) + rem) >> NIPC_LOG2;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_cmd(input logic [CP_W-1:0] ins, input logic [CP_W-1:0] rem,
                           input logic [CFG_W-1:0] cfg);
    int n;
    @(posedge clk); #1;
    cmd_tdata  = {ins, rem, cfg};
    cmd_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_tready) break;
      n++;
      if (n > 60) begin
        tests_run++; fails++;
        $display("FAIL cmd_accept_timeout: cmd_tready=%0b required 1 within 60 cycles", cmd_tready);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cmd_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int nbeats, input bit with_last, input bit done_on_last);
    logic [DW-1:0] d;
    logic          l;
    int            w;
    @(posedge clk); #1;
    for (int b = 1; b <= nbeats; b++) begin
      for (int j = 0; j < NIPC; j++) d[j*32 +: 32] = $urandom;
      l = with_last && (b == nbeats);
      i_tdata  = d;
      i_tlast  = l;
      i_tvalid = 1'b1;
      if (l && done_on_last) begin
        done_tvalid = 1'b1;
        done_tlast  = 1'b1;
      end
      exp_q.push_back({l, d});
      w = 0;
      forever begin
        @(negedge clk);
        if (i_tready) break;
        w++;
        if (w > 60) begin
          tests_run++; fails++;
          $display("FAIL beat_accept_timeout: beat %0d i_tready=%0b required 1", b, i_tready);
          break;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      done_tvalid = 1'b0;
      done_tlast  = 1'b0;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  // ---------------- scoreboard / monitors ----------------
  always @(negedge clk) begin
    if (rst_n && p_tvalid && p_tready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_beat: got data=%h last=%0b, required no beat", p_tdata, p_tlast);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        if ({p_tlast, p_tdata} !== e) begin
          fails++;
          $display("FAIL sb_beat: got last=%0b data=%h, required last=%0b data=%h",
                   p_tlast, p_tdata, e[DW], e[DW-1:0]);
        end
      end
    end
  end

  always @(negedge clk) if (err_len === 1'b1) err_cnt++;

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests_run++;
    if ({cmd_tready, fft_config_tvalid, cp_rem_tvalid, cp_ins_tvalid, i_tready, p_tvalid} !== 6'b0) begin
      fails++;
      $display("FAIL reset_valids: got %b, required 000000",
               {cmd_tready, fft_config_tvalid, cp_rem_tvalid, cp_ins_tvalid, i_tready, p_tvalid});
    end
    tests_run++;
    if ({outstanding, err_len, busy, dbg_state} !== 8'h00) begin
      fails++;
      $display("FAIL reset_state: got out=%0d err=%0b busy=%0b st=%0d, required all 0",
               outstanding, err_len, busy, dbg_state);
    end
    tests_run++;
    if ({fft_config_tdata, cp_rem_tdata, cp_ins_tdata} !== '0) begin
      fails++;
      $display("FAIL reset_token_data: got %h/%h/%h, required 0", fft_config_tdata, cp_rem_tdata, cp_ins_tdata);
    end
    do_reset();
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (cmd_tready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: cmd_tready=%0b required 1", cmd_tready);
    end
  endtask

  task automatic test_basic();
    int n;
    fft_size_log2 = 6;
    n = exp_len(6, 16);
    err_cnt = 0;
    drive_cmd(12'd4, 12'd16, 16'h1234);
    @(negedge clk);
    tests_run++;
    if ({fft_config_tvalid, cp_rem_tvalid, cp_ins_tvalid, i_tready, busy} !== 5'b11101) begin
      fails++;
      $display("FAIL basic_tokens_valid: got v=%b i_tready=%0b busy=%0b, required 111 0 1",
               {fft_config_tvalid, cp_rem_tvalid, cp_ins_tvalid}, i_tready, busy);
    end
    tests_run++;
    if (fft_config_tdata !== 16'h1234 || cp_rem_tdata !== 12'd16 || cp_ins_tdata !== 12'd4) begin
      fails++;
      $display("FAIL basic_token_data: got cfg=%h rem=%0d ins=%0d, required 1234/16/4",
               fft_config_tdata, cp_rem_tdata, cp_ins_tdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if ({fft_config_tvalid, cp_rem_tvalid, cp_ins_tvalid, i_tready} !== 4'b0001) begin
      fails++;
      $display("FAIL basic_pass_entry: got v=%b i_tready=%0b, required 000 1",
               {fft_config_tvalid, cp_rem_tvalid, cp_ins_tvalid}, i_tready);
    end
    send_pkt(n, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outstanding !== 4'd1 || err_cnt != 0) begin
      fails++;
      $display("FAIL basic_done: got out=%0d err_pulses=%0d, required 1 and 0", outstanding, err_cnt);
    end
  endtask

  task automatic test_token_order();
    cp_ins_tready = 1'b0;
    drive_cmd(12'd7, 12'd16, 16'hbeef);
    @(negedge clk);
    tests_run++;
    if ({fft_config_tvalid, cp_rem_tvalid, cp_ins_tvalid} !== 3'b111) begin
      fails++;
      $display("FAIL order_first: got %b required 111", {fft_config_tvalid, cp_rem_tvalid, cp_ins_tvalid});
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if ({fft_config_tvalid, cp_rem_tvalid, cp_ins_tvalid, i_tready} !== 4'b0010) begin
        fails++;
        $display("FAIL order_hold: cycle %0d got v=%b i_tready=%0b, required 001 0",
                 c, {fft_config_tvalid, cp_rem_tvalid, cp_ins_tvalid}, i_tready);
      end
    end
    @(posedge clk); #1;
    cp_ins_tready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (cp_ins_tvalid !== 1'b1 || i_tready !== 1'b0) begin
      fails++;
      $display("FAIL order_accept_cycle: got ins_v=%0b i_tready=%0b, required 1 0", cp_ins_tvalid, i_tready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (cp_ins_tvalid !== 1'b0 || i_tready !== 1'b1) begin
      fails++;
      $display("FAIL order_pass: got ins_v=%0b i_tready=%0b, required 0 1", cp_ins_tvalid, i_tready);
    end
    send_pkt(exp_len(6, 16), 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outstanding !== 4'd2) begin
      fails++;
      $display("FAIL order_outstanding: got %0d required 2", outstanding);
    end
  endtask

  task automatic test_throttle();
    do_reset();
    fft_size_log2 = 2;
    for (int k = 0; k < MAX_OUT; k++) begin
      drive_cmd(12'(k), 12'd0, 16'(k));
      send_pkt(exp_len(2, 0), 1'b1, 1'b0);
    end
    @(negedge clk);
    tests_run++;
    if (outstanding !== 4'(MAX_OUT) || cmd_tready !== 1'b0) begin
      fails++;
      $display("FAIL throttle_full: got out=%0d cmd_tready=%0b, required %0d 0", outstanding, cmd_tready, MAX_OUT);
    end
    @(posedge clk); #1;
    cmd_tdata  = {12'd9, 12'd0, 16'h0005};
    cmd_tvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (cmd_tready !== 1'b0 || fft_config_tvalid !== 1'b0) begin
        fails++;
        $display("FAIL throttle_blocked: cycle %0d cmd_tready=%0b cfg_v=%0b, required 0 0",
                 c, cmd_tready, fft_config_tvalid);
      end
      @(posedge clk); #1;
    end
    done_tvalid = 1'b1;
    done_tlast  = 1'b1;
    @(negedge clk);
    tests_run++;
    if (cmd_tready !== 1'b0 || outstanding !== 4'(MAX_OUT)) begin
      fails++;
      $display("FAIL throttle_same_cycle: got cmd_tready=%0b out=%0d, required 0 %0d", cmd_tready, outstanding, MAX_OUT);
    end
    @(posedge clk); #1;
    done_tvalid = 1'b0;
    done_tlast  = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cmd_tready !== 1'b1 || outstanding !== 4'(MAX_OUT - 1)) begin
      fails++;
      $display("FAIL throttle_reopen: got cmd_tready=%0b out=%0d, required 1 %0d", cmd_tready, outstanding, MAX_OUT - 1);
    end
    @(posedge clk); #1;
    cmd_tvalid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cmd_tready !== 1'b0 || fft_config_tvalid !== 1'b1 || fft_config_tdata !== 16'h0005) begin
      fails++;
      $display("FAIL throttle_fifth_issue: got cmd_tready=%0b cfg_v=%0b cfg=%h, required 0 1 0005",
               cmd_tready, fft_config_tvalid, fft_config_tdata);
    end
    send_pkt(exp_len(2, 0), 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outstanding !== 4'(MAX_OUT) || cmd_tready !== 1'b0) begin
      fails++;
      $display("FAIL throttle_refill: got out=%0d cmd_tready=%0b, required %0d 0", outstanding, cmd_tready, MAX_OUT);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    @(posedge clk); #1;
    done_tvalid = 1'b1;
    done_tlast  = 1'b1;
    @(posedge clk); #1;
    done_tvalid = 1'b0;
    done_tlast  = 1'b0;
    @(negedge clk);
    tests_run++;
    if (outstanding !== 4'd0) begin
      fails++;
      $display("FAIL sim_saturate_zero: got out=%0d required 0", outstanding);
    end
    fft_size_log2 = 3;
    for (int k = 0; k < 2; k++) begin
      drive_cmd(12'd1, 12'd0, 16'(16'h100 + k));
      send_pkt(exp_len(3, 0), 1'b1, 1'b0);
    end
    drive_cmd(12'd1, 12'd0, 16'h0300);
    send_pkt(exp_len(3, 0), 1'b1, 1'b1);
    @(negedge clk);
    tests_run++;
    if (outstanding !== 4'd2 || cmd_tready !== 1'b1) begin
      fails++;
      $display("FAIL sim_inc_dec: got out=%0d cmd_tready=%0b, required 2 1", outstanding, cmd_tready);
    end
  endtask

`ifdef FFT_SCHED_LEN_CHECK_EN
  task automatic test_len_check();
    do_reset();
    fft_size_log2 = 8;
    err_cnt = 0;
    drive_cmd(12'd0, 12'd0, 16'h0a0a);
    send_pkt(60, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (err_len !== 1'b1) begin
      fails++;
      $display("FAIL len_short_pulse: err_len=%0b required 1 after tlast beat 60", err_len);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (err_cnt != 1) begin
      fails++;
      $display("FAIL len_short_count: got %0d pulses, required 1", err_cnt);
    end
    err_cnt = 0;
    drive_cmd(12'd0, 12'd0, 16'h0b0b);
    send_pkt(70, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    tests_run++;
    if (err_cnt != 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL len_long: got %0d pulses, %0d beats pending, required 1 and 0", err_cnt, exp_q.size());
    end
    err_cnt = 0;
    drive_cmd(12'd0, 12'd0, 16'h0c0c);
    send_pkt(64, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    tests_run++;
    if (err_cnt != 0) begin
      fails++;
      $display("FAIL len_exact: got %0d pulses, required 0", err_cnt);
    end
  endtask
`else
  task automatic test_len_disabled();
    fft_size_log2 = 6;
    err_cnt = 0;
    drive_cmd(12'd0, 12'd16, 16'h0d0d);
    send_pkt(5, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    tests_run++;
    if (err_cnt != 0) begin
      fails++;
      $display("FAIL len_disabled: got %0d err pulses, required 0", err_cnt);
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    fft_size_log2 = 6;
    drive_cmd(12'd2, 12'd16, 16'h0e0e);
    send_pkt(exp_len(6, 16), 1'b1, 1'b0);
    drive_cmd(12'd2, 12'd16, 16'h0f0f);
    send_pkt(10, 1'b0, 1'b0);
    i_tvalid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({cmd_tready, fft_config_tvalid, cp_rem_tvalid, cp_ins_tvalid, i_tready, p_tvalid, busy} !== 7'b0 ||
        outstanding !== 4'd0) begin
      fails++;
      $display("FAIL mid_reset_async: got flags=%b out=%0d, required 0000000 0",
               {cmd_tready, fft_config_tvalid, cp_rem_tvalid, cp_ins_tvalid, i_tready, p_tvalid, busy}, outstanding);
    end
    i_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive_cmd(12'd3, 12'd16, 16'h1111);
    @(negedge clk);
    tests_run++;
    if (fft_config_tdata !== 16'h1111 || cp_ins_tdata !== 12'd3 || dbg_state !== 2'd1) begin
      fails++;
      $display("FAIL mid_reset_restart: got cfg=%h ins=%0d st=%0d, required 1111 3 1",
               fft_config_tdata, cp_ins_tdata, dbg_state);
    end
    send_pkt(exp_len(6, 16), 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outstanding !== 4'd1) begin
      fails++;
      $display("FAIL mid_reset_count: got out=%0d required 1", outstanding);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_n = 1'b0;
    fft_size_log2 = '0;
    cmd_tdata = '0;
    cmd_tvalid = 1'b0;
    fft_config_tready = 1'b1;
    cp_rem_tready = 1'b1;
    cp_ins_tready = 1'b1;
    i_tdata = '0;
    i_tlast = 1'b0;
    i_tvalid = 1'b0;
    p_tready = 1'b1;
    done_tlast = 1'b0;
    done_tvalid = 1'b0;
    done_tready = 1'b1;
    test_reset();
    test_basic();
    test_token_order();
    test_throttle();
    test_simultaneous();
`ifdef FFT_SCHED_LEN_CHECK_EN
    test_len_check();
`else
    test_len_disabled();
`endif
    test_reset_mid();
    repeat (2) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d beats never reached p_*, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
